gpu_rect_fill: RTL and testbench
================================

# gpu_rect_fill

Bus-initiator fill engine for the GPU framebuffer's 6502-side write port. It accepts one rectangle command at a time and clips it to the 80×60 cell grid. It then drives a burst of framebuffer writes (CE/RW/ADDR/DATA), one cell per clock, row-major. It can optionally flag a buffer swap on the last write. It sits between a command source (CPU register shim or sequencer) and the framebuffer's write port, replacing per-cell CPU stores for bulk fills and clears.

## Interface
- FB_BASE, 4096: bus address of cell (0,0).
- FB_WIDTH, 80: cells per row.
- FB_HEIGHT, 60: rows.
- CLK_CPU  in  1  clock; all state changes on posedge, so the bus is stable at the framebuffer's negedge sample.
- RESET_N  in  1  reset, synchronous, active-low.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  engine idle; command accepted on posedge with CMD_VALID & CMD_READY.
- CMD_X  in  7  left column.
- CMD_Y  in  6  top row.
- CMD_W  in  7  width in cells.
- CMD_H  in  6  height in rows.
- CMD_COLOR  in  3  {B,G,R} colour.
- CMD_SWAP  in  1  request buffer swap with last write.
- FB_CE  out  1  active-low chip enable.
- FB_RW  out  1  0 = write; low only together with FB_CE.
- FB_ADDR  out  15  bus address.
- FB_DATA  out  7  [2:0] colour, [5:3] zero, [6] swap.
- BUSY  out  1  high whenever not IDLE.
- DONE  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, WRITE, DRAIN1, DRAIN2.
- IDLE: CMD_READY=1, FB_CE=1, FB_RW=1. On accept, register the clipped rectangle, colour and swap, then go to WRITE. If the clipped area is 0, go to DRAIN1.
- Clipping, computed in 8-bit arithmetic:
  - empty if X≥80, Y≥60, W=0 or H=0.
  - w' = min(W, 80−X); h' = min(H, 60−Y).
- WRITE: each cycle FB_CE=0, FB_RW=0, FB_ADDR = FB_BASE + row_base + col, FB_DATA = {swap_last, 3'b0, colour}.
  - col runs X..X+w'−1. At row end, col returns to X and row_base += 80.
  - row_base is held incrementally, with no multiplier; it starts at Y×80, computed once at accept.
  - FB_DATA[6]=1 only on the final write (last col, last row) and only if CMD_SWAP was set. After the final write, go to DRAIN1.
- DRAIN1, DRAIN2: FB_CE=1, FB_RW=1. These give the framebuffer time to commit the last write and apply any swap before the next burst. DONE=1 during DRAIN2, then go to IDLE.
- An empty command with CMD_SWAP=1 produces no writes and no swap; DONE still pulses.
- CMD_VALID is ignored when not IDLE. Command inputs are sampled only at accept.
- FB_ADDR/FB_DATA hold their last value while idle.

## Timing
- Reset values: state IDLE, CMD_READY=1, BUSY=0, DONE=0, FB_CE=1, FB_RW=1, FB_ADDR=0, FB_DATA=0.
- Accept at edge k. Cycle n means the interval after edge k+n.
  - Writes occupy cycles 1..N, N = w'·h', back-to-back with no gaps.
  - DRAIN1 is cycle N+1; DRAIN2 is cycle N+2 with DONE=1.
  - CMD_READY=1 from cycle N+3, so back-to-back commands are N+3 cycles apart.
- All outputs are registered; no combinational input-to-output paths.
- RESET_N low in any state takes effect at that edge. FB_CE/FB_RW are high the next cycle. No further writes, no DONE, and a pending swap is dropped.
- Max burst 4800 writes; internal counters must not wrap. Addresses stay within FB_BASE..FB_BASE+4799.

## Structure
- Shared package gpu_pkg: FB_BASE, FB_WIDTH, FB_HEIGHT, state enum, FB_DATA bit positions (colour [2:0], swap bit 6). The framebuffer side uses the same constants.
- One combinational sub-module, gpu_rect_clip: (X,Y,W,H) → (w', h', empty, start row_base). The FSM and address counters stay in gpu_rect_fill.

## Test plan
- Reset: hold RESET_N low 2 cycles → FB_CE=1, FB_RW=1, CMD_READY=1, BUSY=0, DONE=0, FB_ADDR=0.
- Fill X=2, Y=3, W=2, H=2, COLOR=5, SWAP=0 → writes in cycles 1–4 to 4338, 4339, 4418, 4419, all data 0x05. DONE in cycle 6; CMD_READY in cycle 7.
- Single cell X=79, Y=59, W=1, H=1, COLOR=7, SWAP=1 → one write, addr 8895, data 0x47. DONE in cycle 3.
- Clip X=78, Y=58, W=5, H=5, COLOR=1 → exactly 4 writes to 8814, 8815, 8894, 8895, data 0x01. No address above 8895.
- Empty X=80, SWAP=1 → FB_CE never low, DONE in cycle 2, CMD_READY in cycle 3. Also: CMD_VALID during a burst is not accepted.
- Reset mid-burst: 2×2 fill, RESET_N low at the edge starting write 3 → FB_CE=1 from the next cycle, writes 3–4 never issued, no DONE, CMD_READY=1 after reset.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared framebuffer constants, fill-engine state encoding and FB_DATA packing.
// The framebuffer write-port side uses the same constants and bit positions.
package gpu_pkg;

   localparam logic [14:0] FB_BASE   = 15'd4096;
   localparam logic [7:0]  FB_WIDTH  = 8'd80;
   localparam logic [7:0]  FB_HEIGHT = 8'd60;

   localparam int DATA_COLOR_LSB = 0;
   localparam int DATA_COLOR_MSB = 2;
   localparam int DATA_SWAP_BIT  = 6;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WRITE  = 2'd1,
      ST_DRAIN1 = 2'd2,
      ST_DRAIN2 = 2'd3
   } state_e;

   function automatic logic [6:0] fb_data_pack(input logic [2:0] colour, input logic swap);
      logic [6:0] d;
      d = '0;
      d[DATA_COLOR_MSB:DATA_COLOR_LSB] = colour;
      d[DATA_SWAP_BIT] = swap;
      return d;
   endfunction

   function automatic logic [14:0] fb_cell_addr(input logic [12:0] row_base, input logic [6:0] col);
      return FB_BASE + {2'b0, row_base} + {8'b0, col};
   endfunction

endpackage

// File: rtl/gpu_rect_clip.sv
// Combinational clip of a rectangle command against the 80x60 grid.
// Produces clipped width/height, an empty flag and the starting row base (Y*80).
module gpu_rect_clip
   import gpu_pkg::*;
(
   input  logic [6:0]  x,
   input  logic [5:0]  y,
   input  logic [6:0]  w,
   input  logic [5:0]  h,
   output logic [6:0]  w_clip,
   output logic [5:0]  h_clip,
   output logic        empty,
   output logic [12:0] row_base
);

   logic [7:0] rem_w;
   logic [7:0] rem_h;

   always_comb begin
      rem_w = FB_WIDTH - {1'b0, x};
      rem_h = FB_HEIGHT - {2'b0, y};
      // A start coordinate past the edge either hits zero or underflows into bit 7.
      empty = rem_w[7] || (rem_w == 8'd0) || rem_h[7] || (rem_h == 8'd0) ||
              (w == 7'd0) || (h == 6'd0);
      w_clip = '0;
      h_clip = '0;
      if (!empty) begin
         w_clip = ({1'b0, w} < rem_w) ? w : rem_w[6:0];
         h_clip = ({2'b0, h} < rem_h) ? h : rem_h[5:0];
      end
      row_base = {1'b0, y, 6'b0} + {3'b0, y, 4'b0};
   end

endmodule

// File: rtl/gpu_rect_fill.sv
// Rectangle fill engine: accepts one command, clips it, then writes one cell per clock row-major.
// All outputs registered; DONE pulses two cycles after the last write, then CMD_READY returns.
module gpu_rect_fill (
   input  logic        CLK_CPU,
   input  logic        RESET_N,
   input  logic        CMD_VALID,
   output logic        CMD_READY,
   input  logic [6:0]  CMD_X,
   input  logic [5:0]  CMD_Y,
   input  logic [6:0]  CMD_W,
   input  logic [5:0]  CMD_H,
   input  logic [2:0]  CMD_COLOR,
   input  logic        CMD_SWAP,
   output logic        FB_CE,
   output logic        FB_RW,
   output logic [14:0] FB_ADDR,
   output logic [6:0]  FB_DATA,
   output logic        BUSY,
   output logic        DONE
);
   import gpu_pkg::*;

   state_e      state_q, state_d;
   logic [6:0]  x_q, x_d;
   logic [6:0]  col_q, col_d;
   logic [6:0]  xend_q, xend_d;
   logic [5:0]  rows_left_q, rows_left_d;
   logic [12:0] row_base_q, row_base_d;
   logic [2:0]  colour_q, colour_d;
   logic        swap_q, swap_d;
   logic        fb_ce_q, fb_ce_d;
   logic        fb_rw_q, fb_rw_d;
   logic [14:0] fb_addr_q, fb_addr_d;
   logic [6:0]  fb_data_q, fb_data_d;
   logic        ready_q, ready_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic [6:0]  clip_w;
   logic [5:0]  clip_h;
   logic        clip_empty;
   logic [12:0] clip_row_base;

   gpu_rect_clip u_clip (
      .x        (CMD_X),
      .y        (CMD_Y),
      .w        (CMD_W),
      .h        (CMD_H),
      .w_clip   (clip_w),
      .h_clip   (clip_h),
      .empty    (clip_empty),
      .row_base (clip_row_base)
   );

   // Registered outputs always describe the cell on the bus; the counters point at that same cell.
   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      col_d       = col_q;
      xend_d      = xend_q;
      rows_left_d = rows_left_q;
      row_base_d  = row_base_q;
      colour_d    = colour_q;
      swap_d      = swap_q;
      fb_ce_d     = 1'b1;
      fb_rw_d     = 1'b1;
      fb_addr_d   = fb_addr_q;
      fb_data_d   = fb_data_q;
      done_d      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (CMD_VALID) begin
               colour_d    = CMD_COLOR;
               x_d         = CMD_X;
               col_d       = CMD_X;
               xend_d      = CMD_X + clip_w - 7'd1;
               rows_left_d = clip_h - 6'd1;
               row_base_d  = clip_row_base;
               if (clip_empty) begin
                  state_d = ST_DRAIN1;
                  swap_d  = 1'b0;
               end else begin
                  state_d   = ST_WRITE;
                  swap_d    = CMD_SWAP;
                  fb_ce_d   = 1'b0;
                  fb_rw_d   = 1'b0;
                  fb_addr_d = fb_cell_addr(clip_row_base, CMD_X);
                  fb_data_d = fb_data_pack(CMD_COLOR,
                                           CMD_SWAP && (clip_w == 7'd1) && (clip_h == 6'd1));
               end
            end
         end
         ST_WRITE: begin
            if ((col_q == xend_q) && (rows_left_q == 6'd0)) begin
               state_d = ST_DRAIN1;
            end else begin
               if (col_q == xend_q) begin
                  col_d       = x_q;
                  row_base_d  = row_base_q + {5'b0, FB_WIDTH};
                  rows_left_d = rows_left_q - 6'd1;
               end else begin
                  col_d = col_q + 7'd1;
               end
               fb_ce_d   = 1'b0;
               fb_rw_d   = 1'b0;
               fb_addr_d = fb_cell_addr(row_base_d, col_d);
               fb_data_d = fb_data_pack(colour_q,
                                        swap_q && (col_d == xend_q) && (rows_left_d == 6'd0));
            end
         end
         ST_DRAIN1: begin
            state_d = ST_DRAIN2;
            done_d  = 1'b1;
         end
         ST_DRAIN2: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      ready_d = (state_d == ST_IDLE);
      busy_d  = (state_d != ST_IDLE);
   end

   always_ff @(posedge CLK_CPU) begin
      if (!RESET_N) begin
         state_q     <= ST_IDLE;
         x_q         <= '0;
         col_q       <= '0;
         xend_q      <= '0;
         rows_left_q <= '0;
         row_base_q  <= '0;
         colour_q    <= '0;
         swap_q      <= 1'b0;
         fb_ce_q     <= 1'b1;
         fb_rw_q     <= 1'b1;
         fb_addr_q   <= '0;
         fb_data_q   <= '0;
         ready_q     <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         col_q       <= col_d;
         xend_q      <= xend_d;
         rows_left_q <= rows_left_d;
         row_base_q  <= row_base_d;
         colour_q    <= colour_d;
         swap_q      <= swap_d;
         fb_ce_q     <= fb_ce_d;
         fb_rw_q     <= fb_rw_d;
         fb_addr_q   <= fb_addr_d;
         fb_data_q   <= fb_data_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign CMD_READY = ready_q;
   assign BUSY      = busy_q;
   assign DONE      = done_q;
   assign FB_CE     = fb_ce_q;
   assign FB_RW     = fb_rw_q;
   assign FB_ADDR   = fb_addr_q;
   assign FB_DATA   = fb_data_q;

endmodule

// File: tb/tb_gpu_rect_fill.sv
// Directed bench for gpu_rect_fill: fill, single cell with swap, clipping, empty command, reset mid-burst.
// Outputs are sampled 1 time unit after each rising edge, where inputs are also driven.
module tb_gpu_rect_fill;

   logic        clk_cpu;
   logic        reset_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [6:0]  cmd_x;
   logic [5:0]  cmd_y;
   logic [6:0]  cmd_w;
   logic [5:0]  cmd_h;
   logic [2:0]  cmd_color;
   logic        cmd_swap;
   logic        fb_ce;
   logic        fb_rw;
   logic [14:0] fb_addr;
   logic [6:0]  fb_data;
   logic        busy;
   logic        done;

   int n_tests = 0;
   int n_fail  = 0;

   gpu_rect_fill dut (
      .CLK_CPU   (clk_cpu),
      .RESET_N   (reset_n),
      .CMD_VALID (cmd_valid),
      .CMD_READY (cmd_ready),
      .CMD_X     (cmd_x),
      .CMD_Y     (cmd_y),
      .CMD_W     (cmd_w),
      .CMD_H     (cmd_h),
      .CMD_COLOR (cmd_color),
      .CMD_SWAP  (cmd_swap),
      .FB_CE     (fb_ce),
      .FB_RW     (fb_rw),
      .FB_ADDR   (fb_addr),
      .FB_DATA   (fb_data),
      .BUSY      (busy),
      .DONE      (done)
   );

   initial clk_cpu = 1'b0;
   always #5 clk_cpu = ~clk_cpu;

   task automatic tick();
      @(posedge clk_cpu);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Presents a command for exactly one edge; returns in cycle 1 after the accept edge.
   task automatic send(input logic [6:0] x, input logic [5:0] y, input logic [6:0] w,
                       input logic [5:0] h, input logic [2:0] c, input logic s);
      cmd_x     = x;
      cmd_y     = y;
      cmd_w     = w;
      cmd_h     = h;
      cmd_color = c;
      cmd_swap  = s;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
   endtask

   logic [14:0] exp_fill [4];
   logic [14:0] exp_clip [4];
   logic [14:0] exp_rst  [4];
   int          bad_cnt;

   initial begin
      exp_fill = '{15'd4338, 15'd4339, 15'd4418, 15'd4419};
      exp_clip = '{15'd8814, 15'd8815, 15'd8894, 15'd8895};
      exp_rst  = '{15'd4096, 15'd4097, 15'd4176, 15'd4177};

      reset_n   = 1'b0;
      cmd_valid = 1'b0;
      cmd_x     = '0;
      cmd_y     = '0;
      cmd_w     = '0;
      cmd_h     = '0;
      cmd_color = '0;
      cmd_swap  = 1'b0;
      tick();
      tick();
      chk("rst_ce", fb_ce, 1);
      chk("rst_rw", fb_rw, 1);
      chk("rst_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_addr", fb_addr, 0);
      chk("rst_data", fb_data, 0);
      reset_n = 1'b1;
      tick();

      // 2x2 fill at (2,3), colour 5
      send(7'd2, 6'd3, 7'd2, 6'd2, 3'd5, 1'b0);
      chk("fill_busy", busy, 1);
      chk("fill_ready", cmd_ready, 0);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("fill_ce%0d", i), fb_ce, 0);
         chk($sformatf("fill_rw%0d", i), fb_rw, 0);
         chk($sformatf("fill_addr%0d", i), fb_addr, exp_fill[i]);
         chk($sformatf("fill_data%0d", i), fb_data, 32'h05);
         chk($sformatf("fill_done%0d", i), done, 0);
         tick();
      end
      chk("fill_c5_ce", fb_ce, 1);
      chk("fill_c5_done", done, 0);
      chk("fill_c5_busy", busy, 1);
      tick();
      chk("fill_c6_done", done, 1);
      chk("fill_c6_ready", cmd_ready, 0);
      tick();
      chk("fill_c7_ready", cmd_ready, 1);
      chk("fill_c7_done", done, 0);
      chk("fill_c7_busy", busy, 0);

      // Single bottom-right cell with swap
      send(7'd79, 6'd59, 7'd1, 6'd1, 3'd7, 1'b1);
      chk("one_ce", fb_ce, 0);
      chk("one_addr", fb_addr, 8895);
      chk("one_data", fb_data, 32'h47);
      tick();
      chk("one_c2_ce", fb_ce, 1);
      chk("one_c2_done", done, 0);
      tick();
      chk("one_c3_done", done, 1);
      tick();
      chk("one_c4_ready", cmd_ready, 1);
      chk("one_hold_addr", fb_addr, 8895);
      chk("one_hold_data", fb_data, 32'h47);

      // Clipped 5x5 at (78,58); a competing command is held valid throughout the burst
      send(7'd78, 6'd58, 7'd5, 6'd5, 3'd1, 1'b0);
      cmd_x     = 7'd0;
      cmd_y     = 6'd0;
      cmd_w     = 7'd1;
      cmd_h     = 6'd1;
      cmd_color = 3'd2;
      cmd_swap  = 1'b1;
      cmd_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("clip_ce%0d", i), fb_ce, 0);
         chk($sformatf("clip_addr%0d", i), fb_addr, exp_clip[i]);
         chk($sformatf("clip_data%0d", i), fb_data, 32'h01);
         tick();
      end
      chk("clip_c5_ce", fb_ce, 1);
      chk("clip_c5_addr", fb_addr, 8895);
      tick();
      chk("clip_c6_done", done, 1);
      cmd_valid = 1'b0;
      tick();
      chk("clip_c7_ready", cmd_ready, 1);
      tick();
      chk("clip_noacc_busy", busy, 0);
      chk("clip_noacc_ce", fb_ce, 1);

      // Empty command (X off-grid) with swap requested
      send(7'd80, 6'd0, 7'd5, 6'd5, 3'd3, 1'b1);
      chk("empty_c1_ce", fb_ce, 1);
      chk("empty_c1_busy", busy, 1);
      chk("empty_c1_done", done, 0);
      tick();
      chk("empty_c2_ce", fb_ce, 1);
      chk("empty_c2_done", done, 1);
      chk("empty_c2_ready", cmd_ready, 0);
      tick();
      chk("empty_c3_ready", cmd_ready, 1);
      chk("empty_c3_done", done, 0);
      chk("empty_hold_addr", fb_addr, 8895);

      // Reset asserted at the edge that would start write 3
      send(7'd0, 6'd0, 7'd2, 6'd2, 3'd3, 1'b1);
      chk("rmid_addr0", fb_addr, exp_rst[0]);
      chk("rmid_ce0", fb_ce, 0);
      tick();
      chk("rmid_addr1", fb_addr, exp_rst[1]);
      chk("rmid_data1", fb_data, 32'h03);
      reset_n = 1'b0;
      tick();
      chk("rmid_ce", fb_ce, 1);
      chk("rmid_rw", fb_rw, 1);
      chk("rmid_addr", fb_addr, 0);
      chk("rmid_busy", busy, 0);
      reset_n = 1'b1;
      bad_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (fb_ce == 1'b0 || done == 1'b1 || busy == 1'b1) bad_cnt++;
      end
      chk("rmid_quiet", bad_cnt, 0);
      chk("rmid_ready", cmd_ready, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
